// File: rtl/dashcam_mem_pkg.sv
// Shared types and constants for the dashcam memory write path.
package dashcam_mem_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int BYTE_LANES = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_e;

  // One buffered word plus the end-of-segment marker that travels with it.
  typedef struct packed {
    logic                  last;
    logic [MEM_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/dashcam_sync_fifo.sv
// Generic single-clock FIFO. Exposes the head entry and the entry behind it
// so a consumer can stream back-to-back without a bubble after each pop.
module dashcam_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [WIDTH-1:0]       next_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + AW'(1)];
  assign level_o = level_q;

  // Occupancy after this edge's push/pop; a simultaneous push and pop cancel.
  always_comb begin
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/dashcam_stream_writer.sv
// Packs the encoded byte stream into little-endian words, buffers them and
// writes them sequentially into a circular recording region.
module dashcam_stream_writer
  import dashcam_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 24,
  parameter int RING_BASE  = 0,
  parameter int RING_WORDS = 1048576
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_last,
  output logic [MEM_DATA_W-1:0]       mem_data,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_write,
  input  logic                        mem_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        wrapped,
  input  logic                        clear_wrap,
  output logic                        seg_done
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RING_FIRST = ADDR_W'(RING_BASE);
  localparam logic [ADDR_W-1:0] RING_LAST  = ADDR_W'(RING_BASE + RING_WORDS - 1);

  // Packer state
  logic [1:0]            lane_q;
  logic [MEM_DATA_W-1:0] word_q;
  logic [MEM_DATA_W-1:0] packed_word;
  logic                  accept;
  logic                  push;
  fifo_entry_t           push_entry;

  // FIFO interface
  fifo_entry_t head_entry;
  fifo_entry_t next_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  // Drain FSM and address ring
  drain_state_e          state_q, state_d;
  logic                  mem_write_q, mem_write_d;
  logic [MEM_DATA_W-1:0] mem_data_q, mem_data_d;
  logic                  mem_last_q, mem_last_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  wrapped_q, wrapped_d;
  logic                  seg_done_q, seg_done_d;
  logic                  complete;
  logic                  wrap_evt;

  // Only words ever wait in the FIFO, so a full FIFO must stall every byte.
  assign s_ready = !reset && !fifo_full;
  assign accept  = s_valid && s_ready;
  assign push    = accept && (s_last || lane_q == 2'(BYTE_LANES - 1));

  // The incoming byte lands in the current lane; upper lanes are still zero
  // because word_q is cleared after every push.
  genvar gi;
  generate
    for (gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
      assign packed_word[8*gi +: 8] = (lane_q == 2'(gi)) ? s_data : word_q[8*gi +: 8];
    end
  endgenerate

  assign push_entry.last = s_last;
  assign push_entry.data = packed_word;

  // Lane counter and partial word; restart at lane 0 after each push.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (accept) begin
      if (push) begin
        lane_q <= '0;
        word_q <= '0;
      end else begin
        lane_q <= lane_q + 2'd1;
        word_q <= packed_word;
      end
    end
  end

  dashcam_sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .next_o      (next_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  // Drain FSM next state: the head stays in the FIFO until its write completes.
  always_comb begin
    state_d     = state_q;
    mem_write_d = mem_write_q;
    mem_data_d  = mem_data_q;
    mem_last_d  = mem_last_q;
    pop         = 1'b0;
    complete    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          mem_data_d  = head_entry.data;
          mem_last_d  = head_entry.last;
          mem_write_d = 1'b1;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (!mem_busy) begin
          complete = 1'b1;
          pop      = 1'b1;
          if (fifo_level > LW'(1)) begin
            mem_data_d = next_entry.data;
            mem_last_d = next_entry.last;
          end else begin
            mem_write_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address ring and flags; a wrap beats a coincident clear_wrap.
  always_comb begin
    wrap_evt   = complete && (addr_q == RING_LAST);
    addr_d     = addr_q;
    if (complete) begin
      addr_d = wrap_evt ? RING_FIRST : addr_q + ADDR_W'(1);
    end
    wrapped_d  = wrap_evt ? 1'b1 : (clear_wrap ? 1'b0 : wrapped_q);
    seg_done_d = complete && mem_last_q;
  end

  // Drain FSM, output and ring registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_write_q <= 1'b0;
      mem_data_q  <= '0;
      mem_last_q  <= 1'b0;
      addr_q      <= RING_FIRST;
      wrapped_q   <= 1'b0;
      seg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_write_q <= mem_write_d;
      mem_data_q  <= mem_data_d;
      mem_last_q  <= mem_last_d;
      addr_q      <= addr_d;
      wrapped_q   <= wrapped_d;
      seg_done_q  <= seg_done_d;
    end
  end

  assign mem_write = mem_write_q;
  assign mem_data  = mem_data_q;
  assign mem_addr  = addr_q;
  assign wrapped   = wrapped_q;
  assign seg_done  = seg_done_q;

endmodule

// File: tb/tb_dashcam_stream_writer.sv
// Self-checking bench: directed scenarios plus a randomized run, all checked
// against a word-level model of the stream (byte list -> word queue -> ring).
module tb_dashcam_stream_writer;

  localparam int DEPTH = 16;
  localparam int AW    = 24;
  localparam int RB    = 8;
  localparam int RW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [31:0]   mem_data;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic          mem_busy = 1'b0;
  logic [4:0]    fifo_level;
  logic          wrapped;
  logic          clear_wrap = 1'b0;
  logic          seg_done;

  dashcam_stream_writer #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW),
    .RING_BASE  (RB),
    .RING_WORDS (RW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_last     (s_last),
    .mem_data   (mem_data),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .mem_busy   (mem_busy),
    .fifo_level (fifo_level),
    .wrapped    (wrapped),
    .clear_wrap (clear_wrap),
    .seg_done   (seg_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } word_t;

  // Reference model state
  word_t       exp_q[$];
  logic [7:0]  byte_buf[$];
  int          n_wr;
  bit          exp_wrapped;
  bit          exp_seg;

  // Bookkeeping
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            sampled_acc;
  bit            prev_stall = 1'b0;
  logic [31:0]   prev_data;
  logic [AW-1:0] prev_addr;
  int            n_mw, n_writes, n_seg, n_wrp;
  int            first_mw_cyc, last_acc_cyc;
  logic [31:0]   last_wr_data;
  logic [AW-1:0] last_wr_addr;
  int            busy_mode = 0;
  int            accepted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_mw = 0; n_writes = 0; n_seg = 0; n_wrp = 0; first_mw_cyc = -1;
  endtask

  // One clock: sample at the falling edge, advance the model across the
  // rising edge, then update mem_busy per the current mode.
  task automatic tick();
    bit          comp;
    bit          acc;
    bit          wrap_now;
    word_t       w;
    logic [31:0] wd;
    @(negedge clk);
    cyc++;
    check("s_ready", s_ready, (!reset && exp_q.size() < DEPTH));
    if (!reset) begin
      check("fifo_level", fifo_level, exp_q.size());
      check("seg_done", seg_done, exp_seg);
      check("wrapped", wrapped, exp_wrapped);
      if (prev_stall) begin
        check("hold_write", mem_write, 1);
        check("hold_data", mem_data, prev_data);
        check("hold_addr", mem_addr, prev_addr);
      end
    end
    comp = !reset && (mem_write === 1'b1) && !mem_busy;
    acc  = !reset && s_valid && s_ready;
    if (mem_write === 1'b1) begin
      n_mw++;
      if (first_mw_cyc < 0) first_mw_cyc = cyc;
    end
    if (seg_done === 1'b1) n_seg++;
    if (wrapped === 1'b1) n_wrp++;
    prev_stall  = !reset && (mem_write === 1'b1) && mem_busy;
    prev_data   = mem_data;
    prev_addr   = mem_addr;
    sampled_acc = acc;
    if (reset) begin
      exp_q.delete();
      byte_buf.delete();
      n_wr = 0;
      exp_wrapped = 1'b0;
      exp_seg = 1'b0;
    end else begin
      exp_seg  = 1'b0;
      wrap_now = 1'b0;
      if (comp) begin
        n_writes++;
        last_wr_data = mem_data;
        last_wr_addr = mem_addr;
        if (exp_q.size() == 0) begin
          check("spurious_write", mem_write, 0);
        end else begin
          w = exp_q.pop_front();
          check("wr_data", mem_data, w.data);
          check("wr_addr", mem_addr, RB + (n_wr % RW));
          exp_seg  = w.last;
          wrap_now = ((n_wr % RW) == RW - 1);
          n_wr++;
        end
      end
      exp_wrapped = wrap_now ? 1'b1 : (clear_wrap ? 1'b0 : exp_wrapped);
      if (acc) begin
        last_acc_cyc = cyc;
        byte_buf.push_back(s_data);
        if (s_last || byte_buf.size() == 4) begin
          wd = '0;
          foreach (byte_buf[k]) wd = wd | (32'(byte_buf[k]) << (8 * k));
          exp_q.push_back('{wd, s_last});
          byte_buf.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    case (busy_mode)
      0:       mem_busy = 1'b0;
      1:       mem_busy = 1'b1;
      2:       mem_busy = ~mem_busy;
      default: mem_busy = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    int t;
    t = 0;
    s_data = d; s_last = last; s_valid = 1'b1;
    do begin
      tick();
      t++;
    end while (!sampled_acc && t < 500);
    check("send_timeout", sampled_acc, 1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mem_write !== 1'b0) && t < 500) begin
      tick();
      t++;
    end
    tick();
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    clr_stats();
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_mem_addr", mem_addr, RB);
    check("rst_level", fifo_level, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_seg_done", seg_done, 0);

    // One full word, no stall
    clr_stats();
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    drain();
    check("t1_writes", n_writes, 1);
    check("t1_mw_cycles", n_mw, 1);
    check("t1_data", last_wr_data, 32'h44332211);
    check("t1_addr", last_wr_addr, RB);
    check("t1_seg", n_seg, 0);
    check("t1_latency", first_mw_cyc - last_acc_cyc, 2);

    // Full word then a one-byte segment tail
    clr_stats();
    send_byte(8'hA1, 0); send_byte(8'hA2, 0); send_byte(8'hA3, 0); send_byte(8'hA4, 0);
    send_byte(8'h55, 1);
    drain();
    check("t2_writes", n_writes, 2);
    check("t2_seg", n_seg, 1);
    check("t2_data", last_wr_data, 32'h00000055);
    check("t2_addr", last_wr_addr, RB + 2);

    // Backpressure: memory stalled while 80 bytes are offered
    clr_stats();
    busy_mode = 1; mem_busy = 1'b1;
    accepted = 0;
    s_valid = 1'b1; s_last = 1'b0;
    for (int c = 0; c < 100; c++) begin
      s_data = 8'(accepted + 1);
      tick();
      if (sampled_acc) accepted++;
    end
    s_valid = 1'b0;
    check("t3_accepted", accepted, 64);
    check("t3_level_full", fifo_level, DEPTH);
    check("t3_no_writes", n_writes, 0);
    busy_mode = 0; mem_busy = 1'b0;
    while (accepted < 80) begin
      send_byte(8'(accepted + 1), 0);
      accepted++;
    end
    drain();
    check("t3_writes", n_writes, 20);

    // Ring wrap and clear_wrap
    reset = 1'b1; tick(); reset = 1'b0;
    clr_stats();
    for (int i = 0; i < 20; i++) send_byte(8'(8'hC0 + i), 0);
    drain();
    check("t4_writes", n_writes, 5);
    check("t4_wrap_addr", last_wr_addr, RB);
    check("t4_wrapped", wrapped, 1);
    clear_wrap = 1'b1; tick(); clear_wrap = 1'b0;
    check("t4_cleared", wrapped, 0);
    clr_stats();
    clear_wrap = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'(8'hD0 + i), 0);
    drain();
    clear_wrap = 1'b0;
    check("t4_wrap_prio_cycles", n_wrp, 1);

    // Reset discards a partial word
    clr_stats();
    send_byte(8'hEE, 0); send_byte(8'hEF, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t5_level", fifo_level, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    drain();
    check("t5_writes", n_writes, 1);
    check("t5_data", last_wr_data, 32'h04030201);
    check("t5_addr", last_wr_addr, RB);

    // Single-byte segment under a toggling stall
    clr_stats();
    busy_mode = 2; mem_busy = 1'b1;
    send_byte(8'h99, 1);
    drain();
    busy_mode = 0; mem_busy = 1'b0;
    check("t6_writes", n_writes, 1);
    check("t6_data", last_wr_data, 32'h00000099);
    check("t6_seg", n_seg, 1);

    // Randomized traffic
    busy_mode = 3;
    for (int i = 0; i < 400; i++) begin
      clear_wrap = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) != 0) send_byte(8'($urandom), ($urandom_range(0, 7) == 0));
      else tick();
    end
    clear_wrap = 1'b0;
    drain();
    busy_mode = 0; mem_busy = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
